// File: rtl/vending_pkg.sv
// Shared types and constants for the change dispenser.
package vending_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_PULSE,
    S_GAP,
    S_FINISH
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_Q,
    SEL_D,
    SEL_N
  } coin_sel_t;

  localparam logic [7:0] COIN_Q = 8'd25;
  localparam logic [7:0] COIN_D = 8'd10;
  localparam logic [7:0] COIN_N = 8'd5;

endpackage

// File: rtl/release_pulse_gen.sv
// Release-line timer: on fire, drives the selected line for PULSE_CYCLES,
// then holds all lines low for GAP_CYCLES. phase_done marks the last cycle
// of either phase so the controller can step its own state in lock-step.
module release_pulse_gen
  import vending_pkg::*;
#(
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      fire,
  input  coin_sel_t sel,
  output logic      relq,
  output logic      reld,
  output logic      reln,
  output logic      phase_done
);

  localparam int MAXC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {P_IDLE, P_PULSE, P_GAP} phase_t;

  phase_t        phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          relq_q, relq_d;
  logic          reld_q, reld_d;
  logic          reln_q, reln_d;

  // Phase sequencing and down-counter reload.
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    relq_d  = relq_q;
    reld_d  = reld_q;
    reln_d  = reln_q;
    case (phase_q)
      P_IDLE: begin
        if (fire && sel != SEL_NONE) begin
          phase_d = P_PULSE;
          cnt_d   = CW'(PULSE_CYCLES - 1);
          relq_d  = (sel == SEL_Q);
          reld_d  = (sel == SEL_D);
          reln_d  = (sel == SEL_N);
        end
      end
      P_PULSE: begin
        if (cnt_q == '0) begin
          phase_d = P_GAP;
          cnt_d   = CW'(GAP_CYCLES - 1);
          relq_d  = 1'b0;
          reld_d  = 1'b0;
          reln_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      P_GAP: begin
        if (cnt_q == '0) phase_d = P_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: phase_d = P_IDLE;
    endcase
  end

  // Timer and release-line registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= P_IDLE;
      cnt_q   <= '0;
      relq_q  <= 1'b0;
      reld_q  <= 1'b0;
      reln_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      relq_q  <= relq_d;
      reld_q  <= reld_d;
      reln_q  <= reln_d;
    end
  end

  assign relq       = relq_q;
  assign reld       = reld_q;
  assign reln       = reln_q;
  assign phase_done = (phase_q != P_IDLE) && (cnt_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Greedy change dispenser: quarters, then dimes, then nickels, with
// per-denomination inventory and completion/shortfall strobes.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1,
  parameter int CNT_W        = 6,
  parameter int INIT_Q       = 10,
  parameter int INIT_D       = 10,
  parameter int INIT_N       = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       amount,
  input  logic             refill,
  input  logic [CNT_W-1:0] refill_q,
  input  logic [CNT_W-1:0] refill_d,
  input  logic [CNT_W-1:0] refill_n,
  output logic             busy,
  output logic             relq,
  output logic             reld,
  output logic             reln,
  output logic             done,
  output logic             short,
  output logic [7:0]       remain,
  output logic [CNT_W-1:0] inv_q,
  output logic [CNT_W-1:0] inv_d,
  output logic [CNT_W-1:0] inv_n
);

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             short_q, short_d;
  logic [7:0]       remain_q, remain_d;
  logic [CNT_W-1:0] cnt_qtr_q, cnt_qtr_d;
  logic [CNT_W-1:0] cnt_dime_q, cnt_dime_d;
  logic [CNT_W-1:0] cnt_nkl_q, cnt_nkl_d;

  logic      fire;
  coin_sel_t sel;
  logic      phase_done;

  // Controller: coin choice, inventory bookkeeping and phase tracking.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    short_d    = 1'b0;
    remain_d   = remain_q;
    cnt_qtr_d  = cnt_qtr_q;
    cnt_dime_d = cnt_dime_q;
    cnt_nkl_d  = cnt_nkl_q;
    fire       = 1'b0;
    sel        = SEL_NONE;
    case (state_q)
      S_IDLE: begin
        // Refill wins over start; a start in the same cycle is dropped.
        if (refill) begin
          cnt_qtr_d  = refill_q;
          cnt_dime_d = refill_d;
          cnt_nkl_d  = refill_n;
        end else if (start) begin
          remain_d = amount;
          busy_d   = 1'b1;
          state_d  = S_PICK;
        end
      end
      S_PICK: begin
        if (remain_q >= COIN_Q && cnt_qtr_q != '0) begin
          sel       = SEL_Q;
          fire      = 1'b1;
          remain_d  = remain_q - COIN_Q;
          cnt_qtr_d = cnt_qtr_q - CNT_W'(1);
          state_d   = S_PULSE;
        end else if (remain_q >= COIN_D && cnt_dime_q != '0) begin
          sel        = SEL_D;
          fire       = 1'b1;
          remain_d   = remain_q - COIN_D;
          cnt_dime_d = cnt_dime_q - CNT_W'(1);
          state_d    = S_PULSE;
        end else if (remain_q >= COIN_N && cnt_nkl_q != '0) begin
          sel       = SEL_N;
          fire      = 1'b1;
          remain_d  = remain_q - COIN_N;
          cnt_nkl_d = cnt_nkl_q - CNT_W'(1);
          state_d   = S_PULSE;
        end else begin
          // Nothing fits: either finished cleanly or stuck with a residue.
          state_d = S_FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          short_d = (remain_q != '0);
        end
      end
      S_PULSE: if (phase_done) state_d = S_GAP;
      S_GAP:   if (phase_done) state_d = S_PICK;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      short_q    <= 1'b0;
      remain_q   <= '0;
      cnt_qtr_q  <= CNT_W'(INIT_Q);
      cnt_dime_q <= CNT_W'(INIT_D);
      cnt_nkl_q  <= CNT_W'(INIT_N);
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      short_q    <= short_d;
      remain_q   <= remain_d;
      cnt_qtr_q  <= cnt_qtr_d;
      cnt_dime_q <= cnt_dime_d;
      cnt_nkl_q  <= cnt_nkl_d;
    end
  end

  release_pulse_gen #(
    .PULSE_CYCLES(PULSE_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES)
  ) u_rel (
    .clk       (clk),
    .reset     (reset),
    .fire      (fire),
    .sel       (sel),
    .relq      (relq),
    .reld      (reld),
    .reln      (reln),
    .phase_done(phase_done)
  );

  assign busy   = busy_q;
  assign done   = done_q;
  assign short  = short_q;
  assign remain = remain_q;
  assign inv_q  = cnt_qtr_q;
  assign inv_d  = cnt_dime_q;
  assign inv_n  = cnt_nkl_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with hand-computed cycle traces.
module tb_change_dispenser;

  localparam int CNT_W = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [7:0]       amount;
  logic             refill;
  logic [CNT_W-1:0] refill_q, refill_d, refill_n;
  logic             busy, relq, reld, reln, done, short;
  logic [7:0]       remain;
  logic [CNT_W-1:0] inv_q, inv_d, inv_n;

  int n_chk  = 0;
  int n_pass = 0;

  change_dispenser #(
    .PULSE_CYCLES(2), .GAP_CYCLES(1), .CNT_W(CNT_W),
    .INIT_Q(10), .INIT_D(10), .INIT_N(10)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .amount(amount),
    .refill(refill), .refill_q(refill_q), .refill_d(refill_d), .refill_n(refill_n),
    .busy(busy), .relq(relq), .reld(reld), .reln(reln), .done(done), .short(short),
    .remain(remain), .inv_q(inv_q), .inv_d(inv_d), .inv_n(inv_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_refill(input int q, input int d, input int n);
    @(negedge clk);
    refill = 1'b1;
    refill_q = CNT_W'(q); refill_d = CNT_W'(d); refill_n = CNT_W'(n);
    @(posedge clk);
    #1 refill = 1'b0;
  endtask

  // Start a dispense and trace rel lines per cycle after the start edge.
  // Cycle k is observed at the k-th negedge after the edge that samples start.
  // poke>0 drives start+refill (refill counts 1/1/1) during that cycle.
  task automatic run_disp(input logic [7:0] amt, input int poke,
                          output logic [63:0] qm, output logic [63:0] dm,
                          output logic [63:0] nm, output int done_c,
                          output logic sh, output logic bsy1,
                          output logic bsy_done, output logic ovl);
    qm = '0; dm = '0; nm = '0; done_c = -1;
    sh = 1'b0; bsy1 = 1'b0; bsy_done = 1'b1; ovl = 1'b0;
    @(negedge clk);
    amount = amt; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k < 60 && done_c < 0; k++) begin
      @(negedge clk);
      if (relq) qm[k] = 1'b1;
      if (reld) dm[k] = 1'b1;
      if (reln) nm[k] = 1'b1;
      if ((32'(relq) + 32'(reld) + 32'(reln)) > 1) ovl = 1'b1;
      if (k == 1) bsy1 = busy;
      if (done) begin
        done_c = k; sh = short; bsy_done = busy;
      end
      if (k == poke) begin
        start = 1'b1; refill = 1'b1;
        refill_q = 1; refill_d = 1; refill_n = 1;
      end else begin
        start = 1'b0; refill = 1'b0;
      end
    end
    start = 1'b0; refill = 1'b0;
  endtask

  logic [63:0] qm, dm, nm;
  int          dc;
  logic        sh, b1, bd, ov;

  initial begin
    reset = 1'b1; start = 1'b0; amount = '0; refill = 1'b0;
    refill_q = '0; refill_d = '0; refill_n = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'({done, short}), 64'd0);
    chk("rst_rel", 64'({relq, reld, reln}), 64'd0);
    chk("rst_remain", 64'(remain), 64'd0);
    chk("rst_inv", 64'({inv_q, inv_d, inv_n}), 64'({6'd10, 6'd10, 6'd10}));

    // 40c with full inventory: Q, D, N.
    run_disp(8'd40, 0, qm, dm, nm, dc, sh, b1, bd, ov);
    chk("t1_qmask", qm, 64'hC);
    chk("t1_dmask", dm, 64'hC0);
    chk("t1_nmask", nm, 64'hC00);
    chk("t1_done_cyc", 64'(dc), 64'd14);
    chk("t1_short", 64'(sh), 64'd0);
    chk("t1_busy", 64'({b1, bd}), 64'b10);
    chk("t1_overlap", 64'(ov), 64'd0);
    chk("t1_inv", 64'({inv_q, inv_d, inv_n}), 64'({6'd9, 6'd9, 6'd9}));
    chk("t1_remain", 64'(remain), 64'd0);

    // No quarters: 30c becomes three dimes.
    do_refill(0, 9, 9);
    run_disp(8'd30, 0, qm, dm, nm, dc, sh, b1, bd, ov);
    chk("t2_masks", {qm[15:0], nm[15:0], dm[15:0]}, {16'h0, 16'h0, 16'hCCC});
    chk("t2_done", 64'({8'(dc), 7'd0, sh}), 64'({8'd14, 8'd0}));
    chk("t2_inv", 64'({inv_q, inv_d, inv_n}), 64'({6'd0, 6'd6, 6'd9}));

    // 7c: one nickel then shortfall of 2.
    run_disp(8'd7, 0, qm, dm, nm, dc, sh, b1, bd, ov);
    chk("t3_masks", {qm[15:0], dm[15:0], nm[15:0]}, {16'h0, 16'h0, 16'hC});
    chk("t3_done", 64'({8'(dc), 7'd0, sh}), 64'({8'd6, 8'd1}));
    chk("t3_remain", 64'(remain), 64'd2);
    chk("t3_inv_n", 64'(inv_n), 64'd8);

    // Empty inventory partway: one nickel, 10c undispensed.
    do_refill(0, 0, 1);
    run_disp(8'd15, 0, qm, dm, nm, dc, sh, b1, bd, ov);
    chk("t4_nmask", nm, 64'hC);
    chk("t4_done", 64'({8'(dc), 7'd0, sh}), 64'({8'd6, 8'd1}));
    chk("t4_remain", 64'(remain), 64'd10);
    chk("t4_inv", 64'({inv_q, inv_d, inv_n}), 64'd0);

    // start and refill while busy are ignored.
    do_refill(10, 10, 10);
    run_disp(8'd40, 5, qm, dm, nm, dc, sh, b1, bd, ov);
    chk("t5_masks", {qm[15:0], dm[15:0], nm[15:0]}, {16'hC, 16'hC0, 16'hC00});
    chk("t5_done_cyc", 64'(dc), 64'd14);
    chk("t5_inv", 64'({inv_q, inv_d, inv_n}), 64'({6'd9, 6'd9, 6'd9}));
    @(negedge clk);
    chk("t5_idle_busy", 64'(busy), 64'd0);

    // Zero amount: done two cycles after start, no pulses.
    run_disp(8'd0, 0, qm, dm, nm, dc, sh, b1, bd, ov);
    chk("t6_masks", qm | dm | nm, 64'h0);
    chk("t6_done", 64'({8'(dc), 7'd0, sh}), 64'({8'd2, 8'd0}));
    chk("t6_inv", 64'({inv_q, inv_d, inv_n}), 64'({6'd9, 6'd9, 6'd9}));

    // Reset during a quarter pulse.
    @(negedge clk);
    amount = 8'd40; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t7_relq_on", 64'(relq), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t7_outs", 64'({busy, relq, reld, reln, done, short}), 64'd0);
    chk("t7_remain", 64'(remain), 64'd0);
    chk("t7_inv", 64'({inv_q, inv_d, inv_n}), 64'({6'd10, 6'd10, 6'd10}));

    // refill and start together in IDLE: counts load, start dropped.
    @(negedge clk);
    refill = 1'b1; start = 1'b1; amount = 8'd40;
    refill_q = 6'd3; refill_d = 6'd4; refill_n = 6'd5;
    @(posedge clk);
    #1 begin refill = 1'b0; start = 1'b0; end
    @(negedge clk);
    chk("t8_busy", 64'(busy), 64'd0);
    chk("t8_inv", 64'({inv_q, inv_d, inv_n}), 64'({6'd3, 6'd4, 6'd5}));
    repeat (3) @(negedge clk);
    chk("t8_quiet", 64'({busy, relq, reld, reln, done}), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
